// File: rtl/hex_display_scanner_pkg.sv
// Shared types and helpers for the hex display scan controller.
// Holds the per-slot FSM encoding and the counter/index width helper.
package hex_disp_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } scan_state_t;

    // Width of a counter able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_display_scanner_if.sv
// Load port, decoder hookup and display outputs of the hex scan controller.
// The master side is the wrapper/decoder, the slave side is the scanner.
interface hex_display_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load_valid;
    logic                      load_ready;
    logic [4*NUM_DIGITS-1:0]   load_data;
    logic [NUM_DIGITS-1:0]     load_dp;
    logic [NUM_DIGITS-1:0]     blank_mask;
    logic [3:0]                dec_nibble;
    logic [6:0]                dec_seg;
    logic [6:0]                seg_out;
    logic                      dp_out;
    logic [NUM_DIGITS-1:0]     dig_en;

    modport master (
        output load_valid, load_data, load_dp, blank_mask, dec_seg,
        input  load_ready, dec_nibble, seg_out, dp_out, dig_en
    );

    modport slave (
        input  load_valid, load_data, load_dp, blank_mask, dec_seg,
        output load_ready, dec_nibble, seg_out, dp_out, dig_en
    );
endinterface

// File: rtl/CodHex7seg.sv
// Shared combinational hex-to-7-segment decoder, active-high segments.
// seg[0]=a .. seg[6]=g.
module CodHex7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb begin
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
    end
endmodule

// File: rtl/hex_display_scanner_slot_timer.sv
// Slot sequencer: guard/show phase per digit, digit index and frame pulse.
// Exposes next-cycle phase/index so the top can register outputs aligned to it.
module hex_disp_slot_timer
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 1000,
    parameter int GUARD_CYCLES = 16,
    parameter int IDX_W        = cnt_width(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             show_nxt,
    output logic [IDX_W-1:0] idx_nxt,
    output logic             frame_end
);
    localparam int CNT_W = cnt_width(DIGIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] idx;
    logic             slot_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_BLANK;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        slot_end  = (cnt == CNT_LAST);
        frame_end = slot_end && (idx == IDX_LAST);
        cnt_nxt   = slot_end ? '0 : cnt + CNT_W'(1);
        idx_nxt   = idx;
        if (frame_end)
            idx_nxt = '0;
        else if (slot_end)
            idx_nxt = idx + IDX_W'(1);
        state_nxt = state;
        case (state)
            S_BLANK: if (cnt == GUARD_LAST) state_nxt = S_SHOW;
            S_SHOW:  if (slot_end)          state_nxt = S_BLANK;
            default: state_nxt = S_BLANK;
        endcase
    end

    always_comb begin
        show_nxt = (state_nxt == S_SHOW);
    end
endmodule

// File: rtl/hex_display_scanner.sv
// Scan controller: double-buffered nibble word, one shared decoder, one-hot
// digit enables with a dead-time guard at the start of every digit slot.
module hex_display_scanner
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 1000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    hex_display_scanner_if.slave  bus
);
    localparam int IDX_W = cnt_width(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] act_data, pend_data, act_data_nxt;
    logic [NUM_DIGITS-1:0]   act_dp, pend_dp, act_dp_nxt;
    logic                    pend_valid;
    logic                    load_fire, commit;

    logic                    show_nxt, frame_end;
    logic [IDX_W-1:0]        idx_nxt;

    logic [3:0]              nibble_sel;
    logic                    dp_sel, mask_sel;
    logic [NUM_DIGITS-1:0]   onehot_sel;

    logic [3:0]              nibble_p1;
    logic [6:0]              seg_p1;
    logic                    dp_p1;
    logic [NUM_DIGITS-1:0]   dig_en_p1;

    hex_disp_slot_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .DIGIT_CYCLES (DIGIT_CYCLES),
        .GUARD_CYCLES (GUARD_CYCLES),
        .IDX_W        (IDX_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .show_nxt  (show_nxt),
        .idx_nxt   (idx_nxt),
        .frame_end (frame_end)
    );

    assign load_fire = bus.load_valid && !pend_valid;
    assign commit    = frame_end && pend_valid;

    // A load and a commit are mutually exclusive: one needs pend_valid low,
    // the other high, so a word accepted at a frame edge waits a whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_data   <= '0;
            act_dp     <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (commit) begin
                act_data   <= pend_data;
                act_dp     <= pend_dp;
                pend_valid <= 1'b0;
            end
            if (load_fire) begin
                pend_data  <= bus.load_data;
                pend_dp    <= bus.load_dp;
                pend_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        act_data_nxt = commit ? pend_data : act_data;
        act_dp_nxt   = commit ? pend_dp   : act_dp;
        nibble_sel   = '0;
        dp_sel       = 1'b0;
        mask_sel     = 1'b0;
        onehot_sel   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                nibble_sel    = act_data_nxt[4*i +: 4];
                dp_sel        = act_dp_nxt[i];
                mask_sel      = bus.blank_mask[i];
                onehot_sel[i] = 1'b1;
            end
        end
    end

    // p1: registered outputs aligned with the slot phase of the coming cycle;
    // the decoder already sees this slot's nibble during the guard interval.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nibble_p1 <= '0;
            seg_p1    <= '0;
            dp_p1     <= 1'b0;
            dig_en_p1 <= '0;
        end else begin
            nibble_p1 <= nibble_sel;
            if (show_nxt && !mask_sel) begin
                seg_p1    <= bus.dec_seg;
                dp_p1     <= dp_sel;
                dig_en_p1 <= onehot_sel;
            end else begin
                seg_p1    <= '0;
                dp_p1     <= 1'b0;
                dig_en_p1 <= '0;
            end
        end
    end

    assign bus.load_ready = !pend_valid;
    assign bus.dec_nibble = nibble_p1;
    assign bus.seg_out    = seg_p1;
    assign bus.dp_out     = dp_p1;
    assign bus.dig_en     = dig_en_p1;
endmodule
